// File: rtl/xfer_pkg.sv
// Shared types for the transfer sequencer: engine states and arbitration-mode constants.
package xfer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } xfer_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/xfer_sequencer_arb.sv
// Request arbiter: fixed priority (lowest index wins) or round-robin from an internal pointer.
module rr_arbiter
    import xfer_pkg::*;
#(
    parameter int NUM_CH  = 6,
    parameter int RR_MODE = ARB_FIXED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              grant_en,
    output logic [NUM_CH-1:0] grant
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0]  ptr_reg, ptr_next;
    logic [PTR_W-1:0]  win;
    logic [NUM_CH-1:0] grant_raw;
    logic              found;
    int                start;
    int                idx;

    // Scan all channels once, starting at the pointer in round-robin mode.
    always_comb begin
        grant_raw = '0;
        win       = '0;
        found     = 1'b0;
        idx       = 0;
        start     = (RR_MODE == ARB_RR) ? int'(ptr_reg) : 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = start + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && req[idx]) begin
                grant_raw[idx] = 1'b1;
                win            = PTR_W'(idx);
                found          = 1'b1;
            end
        end
    end

    assign grant = grant_en ? grant_raw : '0;

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_en && found) begin
            ptr_next = (win == PTR_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/xfer_sequencer.sv
// Multi-channel copy engine: arbitrates descriptors, then moves one beat at a time as a
// read/write handshake pair, reporting per-channel done/err with an ack timeout.
module xfer_sequencer
    import xfer_pkg::*;
#(
    parameter int NUM_CH  = 6,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8,
    parameter int RR_MODE = ARB_FIXED,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         req_valid,
    output logic [NUM_CH-1:0]         req_ready,
    input  logic [NUM_CH*ADDR_W-1:0]  req_src,
    input  logic [NUM_CH*ADDR_W-1:0]  req_dst,
    input  logic [NUM_CH*LEN_W-1:0]   req_len,
    output logic                      rd_req,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic                      rd_ack,
    input  logic [DATA_W-1:0]         rd_data,
    output logic                      wr_req,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    input  logic                      wr_ack,
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         err,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] active_ch
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [LEN_W-1:0]  len;
    } desc_t;

    xfer_state_t       state_reg, state_next;
    desc_t             desc_reg, desc_next;
    logic [LEN_W-1:0]  beat_reg, beat_next;
    logic [DATA_W-1:0] hold_reg, hold_next;
    logic [CH_W-1:0]   ch_reg, ch_next;
    logic              err_reg, err_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;

    desc_t             desc_arr [NUM_CH];
    desc_t             sel_desc;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   win_idx;
    logic              grant_en;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign desc_arr[gi].src = req_src[gi*ADDR_W +: ADDR_W];
        assign desc_arr[gi].dst = req_dst[gi*ADDR_W +: ADDR_W];
        assign desc_arr[gi].len = req_len[gi*LEN_W +: LEN_W];
    end

    // Grants are suppressed during reset so req_ready reads 0 while rst is high.
    assign grant_en = (state_reg == IDLE) && !rst;

    rr_arbiter #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .grant_en (grant_en),
        .grant    (grant)
    );

    assign req_ready = grant;
    assign busy      = (state_reg != IDLE);
    assign active_ch = ch_reg;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                win_idx = CH_W'(i);
            end
        end
    end

    assign sel_desc = desc_arr[win_idx];

    always_comb begin
        state_next = state_reg;
        desc_next  = desc_reg;
        beat_next  = beat_reg;
        hold_next  = hold_reg;
        ch_next    = ch_reg;
        err_next   = err_reg;
        rd_req     = 1'b0;
        rd_addr    = '0;
        wr_req     = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        done       = '0;
        err        = '0;

        case (state_reg)
            IDLE: begin
                if (|grant) begin
                    desc_next  = sel_desc;
                    ch_next    = win_idx;
                    beat_next  = '0;
                    err_next   = (sel_desc.len == '0);
                    state_next = (sel_desc.len == '0) ? DONE : READ;
                end
            end
            READ: begin
                // The wait limit takes precedence: strobe drops and the beat is abandoned.
                if (wait_reg == WAIT_MAX) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    rd_req  = 1'b1;
                    rd_addr = desc_reg.src + ADDR_W'(beat_reg);
                    if (rd_ack) begin
                        hold_next  = rd_data;
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                if (wait_reg == WAIT_MAX) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    wr_req  = 1'b1;
                    wr_addr = desc_reg.dst + ADDR_W'(beat_reg);
                    wr_data = hold_reg;
                    if (wr_ack) begin
                        beat_next  = beat_reg + 1'b1;
                        state_next = (beat_next == desc_reg.len) ? DONE : READ;
                    end
                end
            end
            DONE: begin
                done[ch_reg] = 1'b1;
                err[ch_reg]  = err_reg;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Wait counter restarts on every state change and only runs while a strobe is pending.
    always_comb begin
        wait_next = '0;
        if ((state_next == state_reg) && ((state_reg == READ) || (state_reg == WRITE))) begin
            wait_next = wait_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            desc_reg  <= '0;
            beat_reg  <= '0;
            hold_reg  <= '0;
            ch_reg    <= '0;
            err_reg   <= 1'b0;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            desc_reg  <= desc_next;
            beat_reg  <= beat_next;
            hold_reg  <= hold_next;
            ch_reg    <= ch_next;
            err_reg   <= err_next;
            wait_reg  <= wait_next;
        end
    end

endmodule

// File: tb/tb_xfer_sequencer.sv
// Randomised bench: a fixed-priority and a round-robin sequencer run side by side against a
// transaction-level reference model, with directed scenarios followed by random traffic.
module tb_xfer_sequencer;

    localparam int NC  = 6;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int LW  = 8;
    localparam int TMO = 4;

    localparam int OP_RD   = 0;
    localparam int OP_WR   = 1;
    localparam int OP_GAP  = 2;
    localparam int OP_DONE = 3;

    logic clk = 1'b0;
    logic rst;

    logic [NC-1:0]    req_valid [2];
    logic [NC-1:0]    req_ready [2];
    logic [NC*AW-1:0] req_src   [2];
    logic [NC*AW-1:0] req_dst   [2];
    logic [NC*LW-1:0] req_len   [2];
    logic             rd_req    [2];
    logic [AW-1:0]    rd_addr   [2];
    logic             rd_ack    [2];
    logic [DW-1:0]    rd_data   [2];
    logic             wr_req    [2];
    logic [AW-1:0]    wr_addr   [2];
    logic [DW-1:0]    wr_data   [2];
    logic             wr_ack    [2];
    logic [NC-1:0]    done      [2];
    logic [NC-1:0]    err       [2];
    logic             busy      [2];
    logic [2:0]       active_ch [2];

    always #5 clk = ~clk;

    // Instance 0 runs fixed priority, instance 1 round-robin.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        xfer_sequencer #(
            .NUM_CH  (NC),
            .ADDR_W  (AW),
            .DATA_W  (DW),
            .LEN_W   (LW),
            .RR_MODE (gi),
            .TIMEOUT (TMO)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_src   (req_src[gi]),
            .req_dst   (req_dst[gi]),
            .req_len   (req_len[gi]),
            .rd_req    (rd_req[gi]),
            .rd_addr   (rd_addr[gi]),
            .rd_ack    (rd_ack[gi]),
            .rd_data   (rd_data[gi]),
            .wr_req    (wr_req[gi]),
            .wr_addr   (wr_addr[gi]),
            .wr_data   (wr_data[gi]),
            .wr_ack    (wr_ack[gi]),
            .done      (done[gi]),
            .err       (err[gi]),
            .busy      (busy[gi]),
            .active_ch (active_ch[gi])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit rand_req = 1'b0;
    bit spur     = 1'b0;
    bit no_ack   = 1'b0;
    bit repost   = 1'b0;
    int ack_pct  = 100;

    // Requester side: 0 idle, 1 requesting, 2 waiting for done.
    int            rq_st  [2][NC];
    logic [AW-1:0] rq_src [2][NC];
    logic [AW-1:0] rq_dst [2][NC];
    int            rq_len [2][NC];

    // Reference model of the transfer currently owning each engine.
    int            m_busy [2];
    int            m_op   [2];
    int            m_ch   [2];
    int            m_beat [2];
    int            m_len  [2];
    int            m_wait [2];
    int            m_err  [2];
    int            m_ptr  [2];
    int            m_gcyc [2];
    int            m_fast [2];
    logic [AW-1:0] m_src  [2];
    logic [AW-1:0] m_dst  [2];
    logic [DW-1:0] m_data [2];
    bit            ack_dec[2];

    int g0_ch[$];
    int g0_cyc[$];
    int g1_ch[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input int k);
        int start;
        int c;
        start = (k == 1) ? m_ptr[k] : 0;
        for (int i = 0; i < NC; i++) begin
            c = (start + i) % NC;
            if (req_valid[k][c]) return c;
        end
        return -1;
    endfunction

    task automatic post(input int k, input int ch, input logic [AW-1:0] s,
                        input logic [AW-1:0] d, input int len);
        rq_st[k][ch]  = 1;
        rq_src[k][ch] = s;
        rq_dst[k][ch] = d;
        rq_len[k][ch] = len;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_op[k] = OP_RD; m_ch[k] = 0; m_beat[k] = 0;
            m_len[k] = 0; m_wait[k] = 0; m_err[k] = 0; m_ptr[k] = 0;
            for (int ch = 0; ch < NC; ch++) rq_st[k][ch] = 0;
        end
    endtask

    task automatic drive(input int k);
        logic [AW-1:0] s;
        for (int ch = 0; ch < NC; ch++) begin
            if (rq_st[k][ch] == 1 && rand_req && $urandom_range(0, 39) == 0) begin
                rq_st[k][ch] = 0;
            end else if (rq_st[k][ch] == 0 && repost) begin
                post(k, ch, AW'(16'h0100 + ch * 16), AW'(16'h0800 + ch * 16), 1);
            end else if (rq_st[k][ch] == 0 && rand_req && $urandom_range(0, 5) == 0) begin
                s = ($urandom_range(0, 3) == 0) ? 16'hFFFE : AW'($urandom);
                post(k, ch, s, AW'($urandom), $urandom_range(0, 6));
            end
            req_valid[k][ch]        = (rq_st[k][ch] == 1);
            req_src[k][ch*AW +: AW] = rq_src[k][ch];
            req_dst[k][ch*AW +: AW] = rq_dst[k][ch];
            req_len[k][ch*LW +: LW] = LW'(rq_len[k][ch]);
        end
        rd_data[k] = $urandom;
        ack_dec[k] = !no_ack && ($urandom_range(0, 99) < ack_pct);
        rd_ack[k]  = spur && ($urandom_range(0, 3) == 0);
        wr_ack[k]  = spur && ($urandom_range(0, 3) == 0);
        if (m_busy[k] != 0 && m_op[k] == OP_RD) rd_ack[k] = ack_dec[k];
        if (m_busy[k] != 0 && m_op[k] == OP_WR) wr_ack[k] = ack_dec[k];
        if (m_busy[k] != 0 && m_op[k] == OP_GAP) begin
            rd_ack[k] = 1'b0;
            wr_ack[k] = 1'b0;
        end
    endtask

    task automatic check_update(input int k);
        int            w;
        logic [63:0]   ev;
        logic [AW-1:0] ea;
        string         p;
        p = $sformatf("u%0d.", k);
        if (m_busy[k] == 0) begin
            w  = pick(k);
            ev = (w >= 0) ? (64'd1 << w) : 64'd0;
            chk({p, "req_ready"}, req_ready[k], ev);
            chk({p, "idle_outs"}, {busy[k], rd_req[k], wr_req[k], done[k], err[k]}, 0);
            chk({p, "active_ch_hold"}, active_ch[k], m_ch[k]);
            if (w >= 0) begin
                if (k == 0) begin g0_ch.push_back(w); g0_cyc.push_back(cyc); end
                else g1_ch.push_back(w);
                m_busy[k] = 1; m_ch[k] = w; m_src[k] = rq_src[k][w]; m_dst[k] = rq_dst[k][w];
                m_len[k] = rq_len[k][w]; m_beat[k] = 0; m_wait[k] = 0;
                m_err[k] = (m_len[k] == 0); m_op[k] = (m_len[k] == 0) ? OP_DONE : OP_RD;
                m_ptr[k] = (w + 1) % NC; m_gcyc[k] = cyc;
                m_fast[k] = (ack_pct == 100 && !no_ack);
                rq_st[k][w] = 2;
            end
        end else begin
            chk({p, "busy_ready"}, {busy[k], req_ready[k]}, {1'b1, 6'd0});
            chk({p, "active_ch"}, active_ch[k], m_ch[k]);
            case (m_op[k])
                OP_RD: begin
                    ea = m_src[k] + AW'(m_beat[k]);
                    chk({p, "rd_phase"}, {rd_req[k], wr_req[k], done[k]}, {1'b1, 1'b0, 6'd0});
                    chk({p, "rd_addr"}, rd_addr[k], ea);
                    if (ack_dec[k]) begin
                        m_data[k] = rd_data[k]; m_op[k] = OP_WR; m_wait[k] = 0;
                    end else begin
                        m_wait[k]++;
                        if (m_wait[k] == TMO) m_op[k] = OP_GAP;
                    end
                end
                OP_WR: begin
                    ea = m_dst[k] + AW'(m_beat[k]);
                    chk({p, "wr_phase"}, {rd_req[k], wr_req[k], done[k]}, {1'b0, 1'b1, 6'd0});
                    chk({p, "wr_addr"}, wr_addr[k], ea);
                    chk({p, "wr_data"}, wr_data[k], m_data[k]);
                    if (ack_dec[k]) begin
                        m_beat[k]++; m_wait[k] = 0;
                        m_op[k] = (m_beat[k] == m_len[k]) ? OP_DONE : OP_RD;
                    end else begin
                        m_wait[k]++;
                        if (m_wait[k] == TMO) m_op[k] = OP_GAP;
                    end
                end
                OP_GAP: begin
                    chk({p, "timeout_gap"}, {rd_req[k], wr_req[k], done[k]}, 0);
                    m_op[k] = OP_DONE; m_err[k] = 1;
                end
                default: begin
                    ev = 64'd1 << m_ch[k];
                    chk({p, "done"}, done[k], ev);
                    chk({p, "err"}, err[k], (m_err[k] != 0) ? ev : 64'd0);
                    chk({p, "done_strobes"}, {rd_req[k], wr_req[k]}, 0);
                    if (m_fast[k] != 0 && m_err[k] == 0)
                        chk({p, "latency"}, cyc - m_gcyc[k], 2 * m_len[k] + 1);
                    m_busy[k] = 0;
                    rq_st[k][m_ch[k]] = 0;
                end
            endcase
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) drive(k);
        #1;
        for (int k = 0; k < 2; k++) check_update(k);
    endtask

    task automatic chk_zero(input int k);
        chk($sformatf("u%0d.rst_ctrl", k),
            {req_ready[k], rd_req[k], wr_req[k], done[k], err[k], busy[k], active_ch[k]}, 0);
        chk($sformatf("u%0d.rst_addr", k), {rd_addr[k], wr_addr[k]}, 0);
        chk($sformatf("u%0d.rst_wdata", k), wr_data[k], 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = '0; rd_ack[k] = 1'b0; wr_ack[k] = 1'b0;
        end
        model_reset();
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) chk_zero(k);
        rst = 1'b0;
    endtask

    function automatic bit quiet();
        for (int k = 0; k < 2; k++) begin
            if (m_busy[k] != 0) return 1'b0;
            for (int ch = 0; ch < NC; ch++) if (rq_st[k][ch] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_quiet(input int limit, input string tag);
        for (int n = 0; n < limit && !quiet(); n++) step();
        chk({tag, ".settled"}, quiet(), 1);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = '0; req_src[k] = '0; req_dst[k] = '0; req_len[k] = '0;
            rd_ack[k] = 1'b0; wr_ack[k] = 1'b0; rd_data[k] = '0; ack_dec[k] = 1'b0;
            for (int ch = 0; ch < NC; ch++) begin
                rq_src[k][ch] = '0; rq_dst[k][ch] = '0; rq_len[k][ch] = 0;
            end
        end
        model_reset();
        do_reset();

        // 3-beat copy on ch2 with immediate acks
        for (int k = 0; k < 2; k++) post(k, 2, 16'h0010, 16'h0080, 3);
        wait_quiet(100, "copy3");

        // ch0 and ch4 together under fixed priority
        g0_ch.delete(); g0_cyc.delete();
        for (int k = 0; k < 2; k++) begin
            post(k, 0, 16'h0200, 16'h0300, 2);
            post(k, 4, 16'h0400, 16'h0500, 2);
        end
        wait_quiet(100, "fixed_pri");
        chk("fixed.grants", g0_ch.size(), 2);
        if (g0_ch.size() >= 2) begin
            chk("fixed.first", g0_ch[0], 0);
            chk("fixed.second", g0_ch[1], 4);
            chk("fixed.spacing", g0_cyc[1] - g0_cyc[0], 6);
        end

        // all channels re-requesting continuously, len=1
        do_reset();
        g1_ch.delete();
        repost = 1'b1;
        repeat (40) step();
        repost = 1'b0;
        wait_quiet(200, "rr_all");
        chk("rr.grants", g1_ch.size() >= 7, 1);
        if (g1_ch.size() >= 7) begin
            for (int i = 0; i < 7; i++) chk($sformatf("rr.order%0d", i), g1_ch[i], i % NC);
        end

        // zero-length descriptor
        for (int k = 0; k < 2; k++) post(k, 1, 16'h1234, 16'h4321, 0);
        wait_quiet(20, "len0");

        // read ack never arrives
        no_ack = 1'b1;
        for (int k = 0; k < 2; k++) post(k, 3, 16'h0040, 16'h0050, 2);
        wait_quiet(40, "timeout");
        no_ack = 1'b0;

        // reset in the middle of a 5-beat transfer on ch2, then check pointer restart
        for (int k = 0; k < 2; k++) post(k, 2, 16'h0600, 16'h0700, 5);
        repeat (4) step();
        do_reset();
        g1_ch.delete();
        for (int k = 0; k < 2; k++) begin
            post(k, 0, 16'h0A00, 16'h0B00, 1);
            post(k, 3, 16'h0C00, 16'h0D00, 1);
        end
        wait_quiet(50, "post_rst");
        chk("rst.rr_grants", g1_ch.size(), 2);
        if (g1_ch.size() >= 2) begin
            chk("rst.rr_first", g1_ch[0], 0);
            chk("rst.rr_second", g1_ch[1], 3);
        end

        // random traffic with variable ack latency and stray acks
        spur = 1'b1; rand_req = 1'b1; ack_pct = 70;
        repeat (3000) step();
        rand_req = 1'b0;
        wait_quiet(500, "random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
